time_split: RTL

TIME_SPLIT -- requirements
Module: time_split

---
 rtl/time_split.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/time_split.sv
// Converts an elapsed centisecond count into cs/sec/min/hr fields using four
// back-to-back bit-serial restoring divisions that share one divider datapath.
module time_split #(
    parameter int CW       = 24,
    parameter int HW       = 5,
    parameter int HOUR_MOD = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] c,
    output logic          busy,
    output logic          valid,
    output logic [6:0]    cs,
    output logic [5:0]    sec,
    output logic [5:0]    min,
    output logic [HW-1:0] hr,
    output logic          ovf
);

    typedef enum logic [2:0] {
        IDLE, DIV_CS, DIV_SEC, DIV_MIN, DIV_HR, DONE
    } state_t;

    localparam logic [5:0] LAST_BIT = 6'(CW - 1);
    localparam logic [6:0] HMOD     = 7'(HOUR_MOD);

    state_t        state, state_next;
    logic          busy_next, valid_next;

    logic [CW-1:0] quo;
    logic [6:0]    rem;
    logic [5:0]    cnt;
    logic [6:0]    cs_r;
    logic [5:0]    sec_r, min_r;
    logic [6:0]    hr_r;
    logic          ovf_r;

    logic [6:0]    divisor;
    logic [7:0]    partial;
    logic          fits;
    logic [6:0]    rem_next;
    logic [CW-1:0] quo_next;
    logic          last;

    // Partial remainder is below the divisor (<=100) before the shift, so the
    // shifted value stays under 200 and fits the 8-bit compare without loss.
    always_comb begin
        divisor = 7'd100;
        case (state)
            DIV_SEC, DIV_MIN: divisor = 7'd60;
            DIV_HR:           divisor = HMOD;
            default:          ;
        endcase
        partial  = {rem, quo[CW-1]};
        fits     = partial >= {1'b0, divisor};
        rem_next = fits ? 7'(partial - {1'b0, divisor}) : partial[6:0];
        quo_next = {quo[CW-2:0], fits};
        last     = cnt == LAST_BIT;
    end

    always_comb begin
        state_next = state;
        busy_next  = busy;
        valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DIV_CS;
                    busy_next  = 1'b1;
                end
            end
            DIV_CS:  if (last) state_next = DIV_SEC;
            DIV_SEC: if (last) state_next = DIV_MIN;
            DIV_MIN: if (last) state_next = DIV_HR;
            DIV_HR:  if (last) state_next = DONE;
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                valid_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            valid <= valid_next;
        end
    end

    // The quotient left in quo after each stage is the next stage's dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            cs_r  <= '0;
            sec_r <= '0;
            min_r <= '0;
            hr_r  <= '0;
            ovf_r <= 1'b0;
            cs    <= '0;
            sec   <= '0;
            min   <= '0;
            hr    <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo <= c;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                DIV_CS, DIV_SEC, DIV_MIN, DIV_HR: begin
                    quo <= quo_next;
                    cnt <= last ? 6'd0 : cnt + 6'd1;
                    rem <= last ? 7'd0 : rem_next;
                    if (last) begin
                        case (state)
                            DIV_CS:  cs_r  <= rem_next;
                            DIV_SEC: sec_r <= rem_next[5:0];
                            DIV_MIN: min_r <= rem_next[5:0];
                            default: begin
                                hr_r  <= rem_next;
                                ovf_r <= |quo_next;
                            end
                        endcase
                    end
                end
                DONE: begin
                    cs  <= cs_r;
                    sec <= sec_r;
                    min <= min_r;
                    hr  <= HW'(hr_r);
                    ovf <= ovf_r;
                end
                default: ;
            endcase
        end
    end

endmodule
